// File: rtl/vram_fill_pkg.sv
// Shared types and defaults for the VRAM fill engine.
package vram_fill_pkg;

    // Default widths match the GPU VRAM write port (4K x 8).
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LEN_WIDTH  = DEFAULT_ADDR_WIDTH + 1;

    // Source of each written word.
    typedef enum logic [1:0] {
        FILL_CONST  = 2'd0,
        FILL_INCR   = 2'd1,
        FILL_STREAM = 2'd2
    } fill_mode_e;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } fill_state_e;

    // Map the raw command mode field; the reserved code behaves as a constant fill.
    function automatic fill_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return FILL_INCR;
            2'd2:    return FILL_STREAM;
            default: return FILL_CONST;
        endcase
    endfunction

endpackage

// File: rtl/vram_fill_datagen.sv
// Combinational word generator: picks the data for the next VRAM write.
module vram_fill_datagen
    import vram_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  fill_mode_e              mode,
    input  logic [DATA_WIDTH-1:0]   value,
    input  logic [ADDR_WIDTH-1:0]   offset,
    input  logic [DATA_WIDTH-1:0]   src_data,
    output logic [DATA_WIDTH-1:0]   word
);

    // Select constant, incrementing (wraps modulo 2**DATA_WIDTH) or streamed data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word = value;
        case (mode)
            FILL_INCR:   word = value + DATA_WIDTH'(offset);
            FILL_STREAM: word = src_data;
            default:     word = value;
        endcase
    end

endmodule

// File: rtl/vram_fill_engine.sv
// VRAM fill engine: accepts one command, then writes one word per cycle
// (constant, incrementing or streamed) to the VRAM write port.
module vram_fill_engine
    import vram_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [DATA_WIDTH-1:0]   cmd_value,
    input  logic                    abort,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [DATA_WIDTH-1:0]   src_data,
    output logic [ADDR_WIDTH-1:0]   vram_addr,
    output logic [DATA_WIDTH-1:0]   vram_wdata,
    output logic                    vram_we,
    output logic                    busy,
    output logic                    done
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    fill_state_e             state, state_next;

    // Latched command.
    fill_mode_e              mode_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [DATA_WIDTH-1:0]   value_q;

    // rem_q counts words still to be issued; offset_q is the index of the next word.
    logic [LEN_WIDTH-1:0]    rem_q;
    logic [ADDR_WIDTH-1:0]   offset_q;

    // Registered write port.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;

    // Issue-side control and generator inputs.
    logic                    accept;
    logic                    issue;
    fill_mode_e              gen_mode;
    logic [DATA_WIDTH-1:0]   gen_value;
    logic [ADDR_WIDTH-1:0]   gen_base;
    logic [ADDR_WIDTH-1:0]   gen_offset;
    logic [DATA_WIDTH-1:0]   gen_word;

    // A word is "issued" in the cycle its value is registered; it appears on the
    // write port one cycle later. CONST/INCR issue word 0 in the accept cycle so
    // the first write lands one cycle after accept; STREAM issues on each beat.
    vram_fill_datagen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datagen (
        .mode     (gen_mode),
        .value    (gen_value),
        .offset   (gen_offset),
        .src_data (src_data),
        .word     (gen_word)
    );

    // Next-state, issue decision and stream handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        src_ready  = 1'b0;
        gen_mode   = mode_q;
        gen_value  = value_q;
        gen_base   = base_q;
        gen_offset = offset_q;
        case (state)
            IDLE: begin
                // Feed the generator from the command bus so word 0 is ready at accept.
                gen_mode   = decode_mode(cmd_mode);
                gen_value  = cmd_value;
                gen_base   = cmd_base;
                gen_offset = '0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    issue      = (cmd_len != '0) && (gen_mode != FILL_STREAM);
                    state_next = (cmd_len == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins: no issue, no beat consumed this cycle.
                    state_next = IDLE;
                end else begin
                    src_ready = (mode_q == FILL_STREAM) && (rem_q != '0);
                    issue     = (rem_q != '0) && ((mode_q != FILL_STREAM) || src_valid);
                    // Last word is on the port now and nothing is left to issue.
                    if (we_q && (rem_q == '0)) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Command latch, progress counters and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= FILL_CONST;
            base_q   <= '0;
            value_q  <= '0;
            rem_q    <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= issue;
            if (issue) begin
                addr_q  <= gen_base + gen_offset;
                wdata_q <= gen_word;
            end
            if (accept) begin
                mode_q   <= gen_mode;
                base_q   <= cmd_base;
                value_q  <= cmd_value;
                rem_q    <= issue ? (cmd_len - LEN_ONE) : cmd_len;
                offset_q <= issue ? ADDR_ONE : '0;
            end else if (issue) begin
                rem_q    <= rem_q - LEN_ONE;
                offset_q <= offset_q + ADDR_ONE;
            end
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign vram_we    = we_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: directed table, hand-written
// corner sequences and randomized commands against a behavioural model.
module tb_vram_fill_engine;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 13;
    localparam int ASPACE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = '0;
    logic [AW-1:0] cmd_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_value = '0;
    logic          abort = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] src_data = '0;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic          vram_we;
    logic          busy;
    logic          done;

    vram_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .cmd_value  (cmd_value),
        .abort      (abort),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int data; } beat_t;
    wr_t   wr_q[$];
    beat_t beat_q[$];
    int    done_q[$];

    // Observe the write port, stream beats and done pulses mid-cycle.
    always @(negedge clk) begin
        if (vram_we)               wr_q.push_back('{cyc, int'(vram_addr), int'(vram_wdata)});
        if (src_valid && src_ready) beat_q.push_back('{cyc, int'(src_data)});
        if (done)                  done_q.push_back(cyc);
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wr_q.delete();
        beat_q.delete();
        done_q.delete();
    endtask

    // Present one command, then run until idle (bounded); optional random source
    // traffic and random cmd_valid noise while busy.
    task automatic run_cmd(input logic [1:0] mode, input logic [AW-1:0] base,
                           input logic [LW-1:0] len, input logic [DW-1:0] value,
                           input bit rand_src, input bit junk, output int acc);
        int t;
        int budget;
        clear_obs();
        cmd_mode  = mode;
        cmd_base  = base;
        cmd_len   = len;
        cmd_value = value;
        cmd_valid = 1'b1;
        acc = cyc;
        step();
        cmd_valid = 1'b0;
        t = 0;
        budget = 12 * int'(len) + 20;
        while (busy && t < budget) begin
            if (junk) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_mode  = 2'($urandom);
                cmd_base  = AW'($urandom);
                cmd_len   = LW'($urandom);
                cmd_value = DW'($urandom);
            end
            if (rand_src) begin
                src_valid = 1'($urandom_range(0, 1));
                src_data  = DW'($urandom);
            end
            step();
            t++;
        end
        cmd_valid = 1'b0;
        src_valid = 1'b0;
        check("cmd_reaches_idle", busy, 1'b0);
    endtask

    // Reference for CONST/INCR: word k at base+k, one per cycle from acc+1.
    task automatic verify_fill(input string name, input int mode, input int base,
                               input int len, input int value, input int acc);
        int mism;
        int ea;
        int ed;
        mism = 0;
        check({name, "_count"}, wr_q.size(), len);
        foreach (wr_q[k]) begin
            ea = (base + k) % ASPACE;
            ed = (mode == 1) ? ((value + k) % 256) : value;
            if (wr_q[k].addr != ea || wr_q[k].data != ed || wr_q[k].cyc != acc + 1 + k) mism++;
        end
        check({name, "_seq"}, mism, 0);
        check({name, "_done_cnt"}, done_q.size(), 1);
        if (done_q.size() > 0) check({name, "_done_cyc"}, done_q[0], acc + 1 + len);
        check({name, "_no_beats"}, beat_q.size(), 0);
    endtask

    // Reference for STREAM: word k carries beat k's byte, one cycle after the beat.
    task automatic verify_stream(input string name, input int base, input int len, input int acc);
        int mism;
        mism = 0;
        check({name, "_beats"}, beat_q.size(), len);
        check({name, "_count"}, wr_q.size(), len);
        if (beat_q.size() == len && wr_q.size() == len) begin
            foreach (wr_q[k]) begin
                if (wr_q[k].addr != (base + k) % ASPACE || wr_q[k].data != beat_q[k].data ||
                    wr_q[k].cyc != beat_q[k].cyc + 1) mism++;
            end
            check({name, "_seq"}, mism, 0);
            check({name, "_done_cnt"}, done_q.size(), 1);
            if (done_q.size() > 0)
                check({name, "_done_cyc"}, done_q[0], (len == 0) ? acc + 1 : beat_q[len-1].cyc + 2);
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [DW-1:0] value;
        int            exp_n;
        int            a_first, d_first, a_last, d_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc;
        bit pv[5];
        logic [DW-1:0] bytes[3];
        int b;

        vecs[0] = '{2'd0, 12'h3FE, 13'd4,    8'hA5, 4,    'h3FE, 'hA5, 'h401, 'hA5};
        vecs[1] = '{2'd1, 12'hFFE, 13'd4,    8'hFE, 4,    'hFFE, 'hFE, 'h001, 'h01};
        vecs[2] = '{2'd0, 12'h123, 13'd0,    8'h77, 0,    0,     0,     0,     0};
        vecs[3] = '{2'd3, 12'h010, 13'd2,    8'h3C, 2,    'h010, 'h3C, 'h011, 'h3C};
        vecs[4] = '{2'd1, 12'h000, 13'd300,  8'h10, 300,  'h000, 'h10, 'h12B, 'h3B};
        vecs[5] = '{2'd0, 12'h800, 13'd4096, 8'hC3, 4096, 'h800, 'hC3, 'h7FF, 'hC3};

        // Reset values while held and after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_we", vram_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", vram_addr, 0);
        check("rst_wdata", vram_wdata, 0);
        check("rst_src_ready", src_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_we", vram_we, 1'b0);
        check("post_rst_done", done, 1'b0);

        // Directed table: CONST/INCR/len0/reserved/long/full-space.
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].mode, vecs[i].base, vecs[i].len, vecs[i].value, 1'b0, 1'b0, acc);
            check($sformatf("v%0d_ret_cyc", i), cyc, acc + int'(vecs[i].len) + 2);
            check($sformatf("v%0d_cmd_ready", i), cmd_ready, 1'b1);
            check($sformatf("v%0d_n", i), wr_q.size(), vecs[i].exp_n);
            if (wr_q.size() > 0 && vecs[i].exp_n > 0) begin
                check($sformatf("v%0d_a_first", i), wr_q[0].addr, vecs[i].a_first);
                check($sformatf("v%0d_d_first", i), wr_q[0].data, vecs[i].d_first);
                check($sformatf("v%0d_a_last", i), wr_q[wr_q.size()-1].addr, vecs[i].a_last);
                check($sformatf("v%0d_d_last", i), wr_q[wr_q.size()-1].data, vecs[i].d_last);
            end
            verify_fill($sformatf("v%0d", i), (vecs[i].mode == 2'd1) ? 1 : 0,
                        int'(vecs[i].base), int'(vecs[i].len), int'(vecs[i].value), acc);
        end

        // STREAM len=3 with valid pattern 1,0,0,1,1 and extra bytes offered afterwards.
        pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bytes = '{8'h11, 8'h22, 8'h33};
        b = 0;
        clear_obs();
        cmd_mode = 2'd2; cmd_base = 12'h200; cmd_len = 13'd3; cmd_value = 8'h00;
        cmd_valid = 1'b1;
        acc = cyc;
        step();
        cmd_valid = 1'b0;
        check("s_src_ready_run", src_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            src_valid = pv[i];
            src_data = pv[i] ? bytes[b] : 8'hEE;
            if (pv[i]) b++;
            step();
        end
        src_valid = 1'b1;
        src_data = 8'h44;
        for (int t = 0; t < 10 && busy; t++) step();
        src_valid = 1'b0;
        check("s_idle", busy, 1'b0);
        check("s_beats", beat_q.size(), 3);
        check("s_writes", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("s_w0_cyc", wr_q[0].cyc, acc + 2);
            check("s_w1_cyc", wr_q[1].cyc, acc + 5);
            check("s_w2_cyc", wr_q[2].cyc, acc + 6);
            check("s_w0_data", wr_q[0].data, 'h11);
            check("s_w1_data", wr_q[1].data, 'h22);
            check("s_w2_data", wr_q[2].data, 'h33);
            check("s_w2_addr", wr_q[2].addr, 'h202);
        end
        check("s_done_cnt", done_q.size(), 1);
        if (done_q.size() == 1) check("s_done_cyc", done_q[0], acc + 7);

        // Abort a full-space CONST fill while the third word is being issued.
        clear_obs();
        cmd_mode = 2'd0; cmd_base = 12'h100; cmd_len = 13'd4096; cmd_value = 8'h5A;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_cmd_ready", cmd_ready, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_we", vram_we, 1'b0);
        check("ab_addr_hold", vram_addr, 'h101);
        check("ab_wdata_hold", vram_wdata, 'h5A);
        repeat (3) step();
        check("ab_writes", wr_q.size(), 2);
        check("ab_no_done", done_q.size(), 0);

        // Abort in STREAM blocks the beat offered in the same cycle.
        clear_obs();
        cmd_mode = 2'd2; cmd_base = 12'h300; cmd_len = 13'd5;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        src_valid = 1'b1;
        src_data = 8'h99;
        abort = 1'b1;
        #1;
        check("ab_s_src_ready", src_ready, 1'b0);
        step();
        abort = 1'b0;
        src_valid = 1'b0;
        check("ab_s_busy", busy, 1'b0);
        repeat (3) step();
        check("ab_s_writes", wr_q.size(), 0);
        check("ab_s_beats", beat_q.size(), 0);
        check("ab_s_no_done", done_q.size(), 0);

        // Asynchronous reset in the middle of a run.
        clear_obs();
        cmd_mode = 2'd1; cmd_base = 12'h050; cmd_len = 13'd50; cmd_value = 8'h01;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_we", vram_we, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_cmd_ready", cmd_ready, 1'b1);
        check("mr_done", done, 1'b0);
        check("mr_addr", vram_addr, 0);
        check("mr_wdata", vram_wdata, 0);
        clear_obs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("mr_no_writes", wr_q.size(), 0);
        check("mr_no_done", done_q.size(), 0);

        // Randomized commands with random source traffic and cmd_valid noise.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]    m;
            logic [AW-1:0] bs;
            logic [LW-1:0] ln;
            logic [DW-1:0] vl;
            m  = 2'($urandom_range(0, 3));
            bs = AW'($urandom);
            ln = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 2)) : LW'($urandom_range(1, 40));
            vl = DW'($urandom);
            run_cmd(m, bs, ln, vl, 1'b1, 1'b1, acc);
            if (m == 2'd2) verify_stream($sformatf("r%0d", i), int'(bs), int'(ln), acc);
            else verify_fill($sformatf("r%0d", i), (m == 2'd1) ? 1 : 0, int'(bs), int'(ln), int'(vl), acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
